// File: rtl/sseg_scan_mux.sv
// sseg_scan_mux
//   Time-multiplexed driver for DIGITS hex digits on a shared active-low
//   seven-segment bus. Each digit is shown for 2^DWELL_W clocks. The anode is
//   PWM-gated by a 4-bit brightness level, and its first dwell cycle is always
//   blanked as an anti-ghosting guard. Digits can blink individually and
//   leading zeros can be suppressed. All display inputs are captured once per
//   frame, so a frame never shows a mix of old and new data.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high
//   hex          digit values, digit i = hex[4i+3:4i], digit 0 rightmost
//   dp           decimal points, active-high
//   blink        per-digit blink enable
//   lz_en        leading-zero suppression enable
//   brightness   duty level, 0 = dimmest, 15 = brightest
//   an           anode enables, active-low (registered)
//   sseg         segments, active-low, bit0=a .. bit6=g, bit7=dp (registered)
//   frame_start  one-cycle pulse on the first output cycle of digit 0
//
// Debug visibility: the scan state is exposed through the dbg_* outputs.

module sseg_scan_mux #(
    parameter int DIGITS  = 4,
    parameter int DWELL_W = 8,
    parameter int BLINK_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   hex,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blink,
    input  logic                  lz_en,
    input  logic [3:0]            brightness,
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            sseg,
    output logic                  frame_start,
    output logic [DWELL_W-1:0]    dbg_dwell_cnt,
    output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0] dbg_digit_idx,
    output logic                  dbg_blink_phase
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // Scan counters
    logic [DWELL_W-1:0] dwell_cnt;
    logic [IDX_W-1:0]   digit_idx;
    logic [BLINK_W-1:0] frame_cnt;
    logic               blink_phase;

    // Frame-coherent shadow copies of the display inputs
    logic [4*DIGITS-1:0] sh_hex;
    logic [DIGITS-1:0]   sh_dp;
    logic [DIGITS-1:0]   sh_blink;
    logic                sh_lz;
    logic [3:0]          sh_bright;

    logic dwell_max;
    logic last_digit;
    logic frame_end;

    assign dwell_max  = &dwell_cnt;
    assign last_digit = (digit_idx == IDX_W'(DIGITS - 1));
    assign frame_end  = dwell_max && last_digit;

    assign dbg_dwell_cnt   = dwell_cnt;
    assign dbg_digit_idx   = digit_idx;
    assign dbg_blink_phase = blink_phase;

    // Active-low pattern with dp off (bit7 = 1)
    function automatic logic [7:0] seg_decode(input logic [3:0] v);
        logic [7:0] s;
        case (v)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    // Leading-zero suppression: walking down from the top digit, a digit is
    // blanked while every digit above it (and itself) is zero with dp clear.
    // Digit 0 always stays visible so a zero value still shows "0".
    logic [DIGITS-1:0] supp;
    logic              supp_run;

    always_comb begin
        supp     = '0;
        supp_run = sh_lz;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (sh_hex[4*i +: 4] != 4'h0 || sh_dp[i]) begin
                supp_run = 1'b0;
            end
            supp[i] = supp_run && (i != 0);
        end
    end

    // Select the current digit's shadowed attributes
    logic [3:0] cur_val;
    logic       cur_dp;
    logic       cur_blink;
    logic       cur_supp;

    always_comb begin
        cur_val   = 4'h0;
        cur_dp    = 1'b0;
        cur_blink = 1'b0;
        cur_supp  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_idx == IDX_W'(i)) begin
                cur_val   = sh_hex[4*i +: 4];
                cur_dp    = sh_dp[i];
                cur_blink = sh_blink[i];
                cur_supp  = supp[i];
            end
        end
    end

    // Anode gating: guard cycle, PWM compare on the top 4 dwell bits,
    // suppression and blink.
    logic              lit;
    logic [DIGITS-1:0] an_next;
    logic [7:0]        seg_next;

    always_comb begin
        lit = (dwell_cnt != '0)
           && (dwell_cnt[DWELL_W-1 -: 4] <= sh_bright)
           && !cur_supp
           && !(cur_blink && blink_phase);
        an_next = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (lit && digit_idx == IDX_W'(i)) begin
                an_next[i] = 1'b0;
            end
        end
        seg_next = seg_decode(cur_val);
        if (cur_dp) begin
            seg_next[7] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dwell_cnt   <= '0;
            digit_idx   <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            sh_hex      <= '0;
            sh_dp       <= '0;
            sh_blink    <= '0;
            sh_lz       <= 1'b0;
            sh_bright   <= 4'h0;
            an          <= '1;
            sseg        <= 8'hFF;
            frame_start <= 1'b0;
        end else begin
            // Outputs decode the counter state present before this edge
            an          <= an_next;
            sseg        <= seg_next;
            frame_start <= (digit_idx == '0) && (dwell_cnt == '0);

            dwell_cnt <= dwell_cnt + 1'b1;
            if (dwell_max) begin
                if (last_digit) begin
                    digit_idx <= '0;
                    frame_cnt <= frame_cnt + 1'b1;
                    if (&frame_cnt) begin
                        blink_phase <= ~blink_phase;
                    end
                end else begin
                    digit_idx <= digit_idx + 1'b1;
                end
            end

            // Capture on the last cycle of the frame so the next frame
            // starts with fresh, consistent data.
            if (frame_end) begin
                sh_hex    <= hex;
                sh_dp     <= dp;
                sh_blink  <= blink;
                sh_lz     <= lz_en;
                sh_bright <= brightness;
            end
        end
    end

endmodule
